// File: rtl/timer_input_conditioner_if.sv
// rtl/timer_input_conditioner_if.sv - button/tick signal bundle for timer_input_conditioner
//
// Purpose: groups the run enable, raw push-buttons and conditioned outputs
//          of the timer input conditioner into one interface.
// Signals:
//   enable        run enable for the tick divider
//   game_bt_raw   raw game push-button, active-low, asynchronous, bouncy
//   config_bt_raw raw config push-button, active-low, asynchronous, bouncy
//   clk_1hz       one-cycle active-high tick
//   game_bt       one-cycle active-low pulse per accepted game press
//   config_bt     one-cycle active-low pulse per accepted config press
// Modports: master drives the inputs and observes the outputs; slave is the conditioner.
interface timer_input_conditioner_if;
  logic enable;
  logic game_bt_raw;
  logic config_bt_raw;
  logic clk_1hz;
  logic game_bt;
  logic config_bt;

  modport master (
    output enable,
    output game_bt_raw,
    output config_bt_raw,
    input  clk_1hz,
    input  game_bt,
    input  config_bt
  );

  modport slave (
    input  enable,
    input  game_bt_raw,
    input  config_bt_raw,
    output clk_1hz,
    output game_bt,
    output config_bt
  );
endinterface

// File: rtl/timer_input_conditioner.sv
// rtl/timer_input_conditioner.sv - button debounce/pulse shaping and 1 Hz tick divider
//
// Purpose: synchronizes and debounces two active-low push-buttons, emitting one
//          active-low pulse per accepted press, and divides the clock into a
//          one-cycle tick that an accepted game press restarts.
// Ports (timer_input_conditioner_btn):
//   clk_i      clock, rising edge
//   reset_i    synchronous active-high reset
//   raw_i      raw active-low button
//   accept_o   combinational: the press is accepted at the coming edge
//   pulse_n_o  registered active-low one-cycle press pulse
// Ports (timer_input_conditioner):
//   clk_50Mhz  sole clock, rising edge
//   reset      synchronous active-high reset
//   bus        timer_input_conditioner_if.slave (enable, raw buttons, outputs)

module timer_input_conditioner_btn #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic raw_i,
  output logic accept_o,
  output logic pulse_n_o
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  logic          sync1_q, sync2_q;
  btn_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_n_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      // Synchronizer flops reset to the released level so a held button
      // must be seen low again through the full debounce.
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      pulse_n_q <= 1'b1;
    end else begin
      sync1_q   <= raw_i;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pulse_n_q <= ~accept_o;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (!sync2_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (sync2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = PRESSED;
          cnt_d    = '0;
          accept_o = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (sync2_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        // Bounce on release returns to PRESSED, which never pulses again.
        if (!sync2_q) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign pulse_n_o = pulse_n_q;
endmodule

module timer_input_conditioner #(
  parameter int TICK_DIV        = 50000000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input logic                          clk_50Mhz,
  input logic                          reset,
  timer_input_conditioner_if.slave     bus
);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] DIV_LAST = TW'(TICK_DIV - 1);

  logic          game_accept;
  logic          cfg_accept_unused;
  logic          game_pulse_n, cfg_pulse_n;
  logic [TW-1:0] div_q, div_d;
  logic          tick_q, tick_d;

  timer_input_conditioner_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_game (
    .clk_i     (clk_50Mhz),
    .reset_i   (reset),
    .raw_i     (bus.game_bt_raw),
    .accept_o  (game_accept),
    .pulse_n_o (game_pulse_n)
  );

  timer_input_conditioner_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_config (
    .clk_i     (clk_50Mhz),
    .reset_i   (reset),
    .raw_i     (bus.config_bt_raw),
    .accept_o  (cfg_accept_unused),
    .pulse_n_o (cfg_pulse_n)
  );

  // Clearing on the same edge that launches the game pulse makes the next
  // tick land exactly TICK_DIV cycles after the pulse cycle.
  always_comb begin
    div_d  = div_q;
    tick_d = 1'b0;
    if (game_accept) begin
      div_d = '0;
    end else if (bus.enable) begin
      if (div_q == DIV_LAST) begin
        div_d  = '0;
        tick_d = 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50Mhz) begin
    if (reset) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  assign bus.clk_1hz   = tick_q;
  assign bus.game_bt   = game_pulse_n;
  assign bus.config_bt = cfg_pulse_n;
endmodule

// File: doc/timer_input_conditioner.md
TIMER_INPUT_CONDITIONER -- requirements
Module: timer_input_conditioner

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- TICK_DIV, 50000000, clk_50Mhz cycles per tick period (1 Hz at 50 MHz).
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a level change (10 ms).
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- clk_50Mhz  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  tick divider run enable.
- game_bt_raw  in  1  raw game push-button, active-low, asynchronous, bouncy.
- config_bt_raw  in  1  raw config push-button, active-low, asynchronous, bouncy.
- clk_1hz  out  1  one-cycle active-high tick, once per TICK_DIV cycles.
- game_bt  out  1  one-cycle active-low pulse per accepted game press.
- config_bt  out  1  one-cycle active-low pulse per accepted config press.
REQ-003 All outputs SHALL be registered; no combinational path from any input to any output.

Function
REQ-004 Each raw button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-005 Each button SHALL have an independent FSM: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-006 IDLE: synced level 0 -> PRESS_WAIT with debounce counter cleared; else stay.
REQ-007 PRESS_WAIT: level 0 increments counter; level 1 -> IDLE, counter cleared, no pulse.
REQ-008 PRESS_WAIT with level 0 and counter == DEBOUNCE_CYCLES-1 -> PRESSED; output pulse SHALL be 0 for exactly the next cycle.
REQ-009 PRESSED: level 1 -> RELEASE_WAIT, counter cleared; held low SHALL produce no further pulse.
REQ-010 RELEASE_WAIT: level 1 increments; level 0 -> PRESSED without pulse; counter == DEBOUNCE_CYCLES-1 with level 1 -> IDLE.
REQ-011 Press-to-pulse latency SHALL be DEBOUNCE_CYCLES+3 cycles from the first edge sampling raw 0, raw held low throughout.
REQ-012 Debounce counter width SHALL be clog2(DEBOUNCE_CYCLES); it SHALL never exceed DEBOUNCE_CYCLES-1.
REQ-013 Tick divider SHALL count 0..TICK_DIV-1 while enable=1 and wrap to 0; clk_1hz=1 for the cycle following the count TICK_DIV-1.
REQ-014 enable=0 SHALL freeze the divider value and force clk_1hz=0; resuming continues from the held count.
REQ-015 An accepted game press (cycle game_bt=0) SHALL clear the divider to 0 so the next tick follows exactly TICK_DIV cycles later; this takes priority over wrap and tick in that cycle.
REQ-016 Config presses SHALL NOT affect the divider.
REQ-017 Simultaneous accepted game and config presses SHALL both pulse in the same cycle; the FSMs never interact.

Reset
REQ-018 reset=1 at a clock edge SHALL set both FSMs to IDLE, counters and divider to 0, synchronizer flops to 1, clk_1hz=0, game_bt=1, config_bt=1.
REQ-019 reset SHALL dominate every other input; a press in progress at reset SHALL yield no pulse, and a button still held at release of reset needs a full debounce before pulsing.

Verification (TICK_DIV=10, DEBOUNCE_CYCLES=4)
REQ-020 Reset, enable=1, buttons high 40 cycles -> clk_1hz pulses at cycles 10,20,30,40 after reset release; game_bt, config_bt constant 1.
REQ-021 game_bt_raw low held 20 cycles -> exactly one game_bt=0 pulse, 7 cycles after first low sample; divider restarts, next clk_1hz 10 cycles after pulse.
REQ-022 game_bt_raw bounce 0,0,1,0,0,1 then high -> no pulse; FSM back in IDLE.
REQ-023 Both raw buttons low on same edge, held 10 cycles -> game_bt and config_bt low together in one cycle.
REQ-024 config_bt_raw low 3 cycles then reset asserted 1 cycle, button still low -> no pulse before reset; one pulse 7 cycles after reset release.
REQ-025 enable=0 at divider count 5 for 8 cycles, then 1 -> no ticks while low; next tick 5 cycles after re-enable.
